pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Parametrised program counter/sequencer for the core fetch stage. Computes next PC from
//  opcode and ALU flags (BA/BL/BG/BE relative branches), supports stalls, selects one of
//  NUM_PROG program entry points on a start pulse, and halts on HALT. Drives instr ROM address.
// PARAMETERS
//  PC_W        8              PC width; all PC arithmetic is modulo 2**PC_W
//  OFF_W       15             width of signed branch offset bamt
//  NUM_PROG    3              number of program entry points
//  START_VEC   {8'd44,8'd25,8'd0}  packed NUM_PROG*PC_W entry table; entry i at [i*PC_W +: PC_W]
//  STACK_DEPTH 4              return-stack entries (used only with PC_CALL_STACK_EN)
// PORTS
//  clk       in   1                 clock, all state updates on posedge
//  reset     in   1                 synchronous, active-high
//  start     in   1                 pulse: begin program prog_sel
//  prog_sel  in   $clog2(NUM_PROG)  entry-point index, sampled with start
//  stall     in   1                 hold PC and state this cycle
//  op        in   5                 opcode (definitions package: BA,BL,BG,BE,HALT,CALL,RET)
//  z         in   1                 zero flag
//  lt        in   1                 less-than flag
//  bamt      in   OFF_W             signed branch offset, relative to current PC
//  PC        out  PC_W              current instruction address
//  running   out  1                 high in RUN
//  done      out  1                 high in HALTED
//  err       out  1                 sticky stack error (0 when macro off)
// BEHAVIOUR
//  - Reset (priority over everything): PC=0, state IDLE, running=0, done=0, err=0, stack empty.
//  - States IDLE, RUN, HALTED. IDLE/HALTED + start -> RUN, PC<=START_VEC[prog_sel] next cycle,
//    done cleared. prog_sel>=NUM_PROG -> entry 0. start in RUN ignored. stall ignored for start.
//  - RUN, stall=0: taken = op==BA | (lt&op==BL) | (!lt&op==BG) | (z&op==BE);
//    taken: PC<=PC+sext(bamt) truncated to PC_W; else PC<=PC+1. One-cycle latency, no bubbles.
//  - RUN, op==HALT, stall=0: PC holds, state->HALTED, done=1 next cycle.
//  - RUN, stall=1: PC, state, stack unchanged regardless of op.
//  - Wrap: PC=2**PC_W-1 +1 -> 0; negative offsets wrap modulo 2**PC_W.
//  - IDLE/HALTED: PC holds; op/flags ignored.
//  - Reset mid-RUN: next cycle IDLE, PC=0; start same cycle as reset is ignored.
// CONFIGURATION
//  PC_CALL_STACK_EN defined: STACK_DEPTH-entry LIFO of PC_W return addresses.
//   CALL (RUN, stall=0): push PC+1, PC<=PC+sext(bamt). Full: no push, jump taken, err<=1.
//   RET: pop, PC<=popped. Empty: PC<=PC+1, err<=1. err clears only on reset.
//   Stack cleared on reset and on every start.
//  Not defined: CALL and RET behave as non-taken (PC+1); no stack storage; err tied 0.
// TESTING
//  1 reset; start, prog_sel=1 -> PC=25, running=1 next cycle; 3 NOPs -> PC=28.
//  2 PC=10, op=BL, lt=1, bamt=-4 -> PC=6; op=BL, lt=0 -> PC=7; op=BE, z=1, bamt=5 -> PC=12.
//  3 PC=255 NOP -> PC=0; PC=2, BA bamt=-3 -> PC=255.
//  4 stall=1 for 3 cycles with op=BA -> PC unchanged; HALT -> done=1, PC held; start sel=2 -> PC=44.
//  5 macro on: PC=5 CALL bamt=+10 -> PC=15; RET -> PC=6; 5 CALLs -> err=1, 5th jumps; RET empty -> PC+1.
//  6 macro off: CALL at PC=5 -> PC=6, err=0; reset during RUN -> PC=0, running=0 next cycle.

Source files
------------

// File: rtl/pc_seq_if.sv
// Fetch-stage sequencer bus: control/flag inputs toward pc_seq and PC/status back.
// The master drives start/op/flags; the slave (pc_seq) returns PC and status.
interface pc_seq_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 15,
  parameter int SEL_W = 2
);
  logic             start;
  logic [SEL_W-1:0] prog_sel;
  logic             stall;
  logic [4:0]       op;
  logic             z;
  logic             lt;
  logic [OFF_W-1:0] bamt;
  logic [PC_W-1:0]  PC;
  logic             running;
  logic             done;
  logic             err;

  modport master (
    output start, prog_sel, stall, op, z, lt, bamt,
    input  PC, running, done, err
  );

  modport slave (
    input  start, prog_sel, stall, op, z, lt, bamt,
    output PC, running, done, err
  );
endinterface

// File: rtl/pc_seq.sv
// Program counter / sequencer for the fetch stage: relative branches, stalls, program entry
// selection and halt. Optional return stack enabled by defining PC_CALL_STACK_EN.
module pc_seq #(
  parameter int                       PC_W        = 8,
  parameter int                       OFF_W       = 15,
  parameter int                       NUM_PROG    = 3,
  parameter logic [NUM_PROG*PC_W-1:0] START_VEC   = {8'd44, 8'd25, 8'd0},
  parameter int                       STACK_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  localparam int SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_BA   = 5'd1;
  localparam logic [4:0] OP_BL   = 5'd2;
  localparam logic [4:0] OP_BG   = 5'd3;
  localparam logic [4:0] OP_BE   = 5'd4;
  localparam logic [4:0] OP_HALT = 5'd5;
  localparam logic [4:0] OP_CALL = 5'd6;
  localparam logic [4:0] OP_RET  = 5'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pc_inc, pc_rel, off_pc, start_pc;
  logic            taken;

  // Entry-point table; an out-of-range prog_sel matches nothing and falls back to entry 0.
  logic [PC_W-1:0]     entry_pc [NUM_PROG];
  logic [NUM_PROG-1:0] entry_hit;

  for (genvar gi = 0; gi < NUM_PROG; gi++) begin : g_entry
    assign entry_pc[gi]  = START_VEC[gi*PC_W +: PC_W];
    assign entry_hit[gi] = (bus.prog_sel == SEL_W'(gi));
  end

  always_comb begin
    start_pc = entry_pc[0];
    for (int i = 1; i < NUM_PROG; i++) begin
      if (entry_hit[i]) start_pc = entry_pc[i];
    end
  end

  // Offset is sign-extended (or truncated) to PC width so the add wraps modulo 2**PC_W.
  if (OFF_W >= PC_W) begin : g_off_trunc
    assign off_pc = bus.bamt[PC_W-1:0];
  end else begin : g_off_sext
    assign off_pc = {{(PC_W-OFF_W){bus.bamt[OFF_W-1]}}, bus.bamt};
  end

  assign pc_inc = pc_reg + PC_W'(1);
  assign pc_rel = pc_reg + off_pc;

  assign taken = (bus.op == OP_BA)
              | (bus.lt  & (bus.op == OP_BL))
              | (!bus.lt & (bus.op == OP_BG))
              | (bus.z   & (bus.op == OP_BE));

`ifdef PC_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp_reg, sp_next, sp_dec;
  logic            err_reg, err_next;
  logic            push;

  assign sp_dec = sp_reg - SP_W'(1);

  // Small LIFO kept in registers: RET needs the top entry in the same cycle.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp_reg[IDX_W-1:0]] <= pc_inc;
  end
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
`ifdef PC_CALL_STACK_EN
    sp_next    = sp_reg;
    err_next   = err_reg;
    push       = 1'b0;
`endif
    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_next = ST_RUN;
          pc_next    = start_pc;
`ifdef PC_CALL_STACK_EN
          sp_next    = '0;
`endif
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          case (bus.op)
            OP_HALT: state_next = ST_HALTED;
`ifdef PC_CALL_STACK_EN
            OP_CALL: begin
              pc_next = pc_rel;
              if (sp_reg < SP_W'(STACK_DEPTH)) begin
                push    = 1'b1;
                sp_next = sp_reg + SP_W'(1);
              end else begin
                err_next = 1'b1;
              end
            end
            OP_RET: begin
              if (sp_reg != '0) begin
                pc_next = stack_mem[sp_dec[IDX_W-1:0]];
                sp_next = sp_dec;
              end else begin
                pc_next  = pc_inc;
                err_next = 1'b1;
              end
            end
`endif
            default: pc_next = taken ? pc_rel : pc_inc;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
`ifdef PC_CALL_STACK_EN
      sp_reg    <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
`ifdef PC_CALL_STACK_EN
      sp_reg    <= sp_next;
      err_reg   <= err_next;
`endif
    end
  end

  assign bus.PC      = pc_reg;
  assign bus.running = (state_reg == ST_RUN);
  assign bus.done    = (state_reg == ST_HALTED);
`ifdef PC_CALL_STACK_EN
  assign bus.err     = err_reg;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: expected PC/status pushed per step, popped one clock later.
module tb_pc_seq;

  localparam logic [4:0] NOP  = 5'd0;
  localparam logic [4:0] BA   = 5'd1;
  localparam logic [4:0] BL   = 5'd2;
  localparam logic [4:0] BG   = 5'd3;
  localparam logic [4:0] BE   = 5'd4;
  localparam logic [4:0] HALT = 5'd5;
  localparam logic [4:0] CALL = 5'd6;
  localparam logic [4:0] RET  = 5'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_seq_if #(.PC_W(8), .OFF_W(15), .SEL_W(2)) bus ();

  pc_seq #(
    .PC_W(8), .OFF_W(15), .NUM_PROG(3),
    .START_VEC({8'd44, 8'd25, 8'd0}), .STACK_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       run;
    logic       dn;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check1(string tag, string what, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s: got %0d expected %0d", tag, what, obs, exp);
  endtask

  task automatic step(string tag, bit rst, bit st, logic [1:0] sel, bit stl,
                      logic [4:0] o, bit zz, bit ll, int amt,
                      logic [7:0] pc, bit run, bit dn, bit er);
    exp_t e;
    reset        = rst;
    bus.start    = st;
    bus.prog_sel = sel;
    bus.stall    = stl;
    bus.op       = o;
    bus.z        = zz;
    bus.lt       = ll;
    bus.bamt     = 15'(amt);
    e = '{tag: tag, pc: pc, run: run, dn: dn, er: er};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check1(e.tag, "PC", bus.PC, e.pc);
    check1(e.tag, "running", 8'(bus.running), 8'(e.run));
    check1(e.tag, "done", 8'(bus.done), 8'(e.dn));
    check1(e.tag, "err", 8'(bus.err), 8'(e.er));
    $display("step %-10s PC=%0d running=%0b done=%0b err=%0b", e.tag, bus.PC, bus.running,
             bus.done, bus.err);
  endtask

  initial begin
    // tag        rst st sel stl op   z  lt amt   PC  run dn er
    step("reset0",  1, 0, 0, 0, NOP, 0, 0,   0,   0, 0, 0, 0);
    step("reset1",  1, 1, 1, 0, NOP, 0, 0,   0,   0, 0, 0, 0);
    step("idle_ba", 0, 0, 0, 0, BA,  0, 0,   7,   0, 0, 0, 0);
    step("start1",  0, 1, 1, 1, NOP, 0, 0,   0,  25, 1, 0, 0);
    step("nop1",    0, 0, 0, 0, NOP, 0, 0,   0,  26, 1, 0, 0);
    step("nop2",    0, 0, 0, 0, NOP, 0, 0,   0,  27, 1, 0, 0);
    step("nop3",    0, 0, 0, 0, NOP, 0, 0,   0,  28, 1, 0, 0);
    step("ba_m18",  0, 0, 0, 0, BA,  0, 0, -18,  10, 1, 0, 0);
    step("bl_t",    0, 0, 0, 0, BL,  0, 1,  -4,   6, 1, 0, 0);
    step("bl_nt",   0, 0, 0, 0, BL,  0, 0,  -4,   7, 1, 0, 0);
    step("be_t",    0, 0, 0, 0, BE,  1, 0,   5,  12, 1, 0, 0);
    step("be_nt",   0, 0, 0, 0, BE,  0, 0,   5,  13, 1, 0, 0);
    step("bg_t",    0, 0, 0, 0, BG,  0, 0,   2,  15, 1, 0, 0);
    step("bg_nt",   0, 0, 0, 0, BG,  0, 1,   2,  16, 1, 0, 0);
    step("ba_top",  0, 0, 0, 0, BA,  0, 0, 239, 255, 1, 0, 0);
    step("wrap",    0, 0, 0, 0, NOP, 0, 0,   0,   0, 1, 0, 0);
    step("nop_1",   0, 0, 0, 0, NOP, 0, 0,   0,   1, 1, 0, 0);
    step("nop_2",   0, 0, 0, 0, NOP, 0, 0,   0,   2, 1, 0, 0);
    step("ba_neg",  0, 0, 0, 0, BA,  0, 0,  -3, 255, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall",  0, 0, 0, 1, BA,  0, 0,   5, 255, 1, 0, 0);
    step("st_inrun",0, 1, 2, 0, NOP, 0, 0,   0,   0, 1, 0, 0);
    step("ba_10",   0, 0, 0, 0, BA,  0, 0,  10,  10, 1, 0, 0);
    step("stl_halt",0, 0, 0, 1, HALT,0, 0,   0,  10, 1, 0, 0);
    step("halt",    0, 0, 0, 0, HALT,0, 0,   0,  10, 0, 1, 0);
    step("hlt_ba",  0, 0, 0, 0, BA,  0, 0,   3,  10, 0, 1, 0);
    step("start2",  0, 1, 2, 0, NOP, 0, 0,   0,  44, 1, 0, 0);
    step("halt2",   0, 0, 0, 0, HALT,0, 0,   0,  44, 0, 1, 0);
    step("start3",  0, 1, 3, 0, NOP, 0, 0,   0,   0, 1, 0, 0);
    step("ba_5",    0, 0, 0, 0, BA,  0, 0,   5,   5, 1, 0, 0);
    step("ba_256",  0, 0, 0, 0, BA,  0, 0, 256,   5, 1, 0, 0);
`ifdef PC_CALL_STACK_EN
    step("call10",  0, 0, 0, 0, CALL,0, 0,  10,  15, 1, 0, 0);
    step("ret",     0, 0, 0, 0, RET, 0, 0,   0,   6, 1, 0, 0);
    step("call_a",  0, 0, 0, 0, CALL,0, 0,   1,   7, 1, 0, 0);
    step("call_b",  0, 0, 0, 0, CALL,0, 0,   1,   8, 1, 0, 0);
    step("call_c",  0, 0, 0, 0, CALL,0, 0,   1,   9, 1, 0, 0);
    step("call_d",  0, 0, 0, 0, CALL,0, 0,   1,  10, 1, 0, 0);
    step("call_ful",0, 0, 0, 0, CALL,0, 0,   1,  11, 1, 0, 1);
    step("stl_ret", 0, 0, 0, 1, RET, 0, 0,   0,  11, 1, 0, 1);
    step("ret_d",   0, 0, 0, 0, RET, 0, 0,   0,  10, 1, 0, 1);
    step("ret_c",   0, 0, 0, 0, RET, 0, 0,   0,   9, 1, 0, 1);
    step("ret_b",   0, 0, 0, 0, RET, 0, 0,   0,   8, 1, 0, 1);
    step("ret_a",   0, 0, 0, 0, RET, 0, 0,   0,   7, 1, 0, 1);
    step("ret_emp", 0, 0, 0, 0, RET, 0, 0,   0,   8, 1, 0, 1);
`else
    step("call_off",0, 0, 0, 0, CALL,0, 0,  10,   6, 1, 0, 0);
    step("ret_off", 0, 0, 0, 0, RET, 0, 0,   0,   7, 1, 0, 0);
`endif
    step("rst_run", 1, 1, 2, 0, BA,  0, 0,   9,   0, 0, 0, 0);
    step("post_rst",0, 0, 0, 0, BA,  0, 0,   9,   0, 0, 0, 0);

    if (sb.size() != 0) begin
      checks++;
      $error("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
